ram_fifo_ctrl: RTL and testbench



---
 rtl/ram_fifo_pkg.sv | 28 ++
 rtl/ram_fifo_ptr.sv | 30 +++
 rtl/ram_fifo_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_pkg
//  Description : Shared types and default sizes for the RAM-backed FIFO
//                controller (state encoding, last-operation tag, widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_fifo_pkg;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;

    // Controller state; every access state returns to IDLE for bus turnaround.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    // Type of the most recent RAM access, used to alternate contested grants.
    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_t;

endpackage
`default_nettype wire

// File: rtl/ram_fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ptr
//  Description : ADDR_W-bit wrapping pointer with increment enable.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset (pointer -> 0)
//                inc   - advance pointer by one at the next edge
//                ptr   - current pointer value
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ptr #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    // Natural binary overflow provides the wrap from DEPTH-1 to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl
//  Description : Turns a single-port 16x8 RAM into a FIFO. One-entry write
//                buffer on the push side, registered output word on the pop
//                side, one RAM access at a time with an IDLE turnaround
//                cycle after every access.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                push_valid/ready/data  - push handshake
//                pop_valid/ready/data   - pop handshake (pop_data registered)
//                count, full, empty     - occupancy status
//                ram_we, ram_en         - RAM write strobe / read enable
//                ram_addr, ram_data     - RAM address / bidirectional data
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ram_we,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    // Count value meaning "all DEPTH RAM locations occupied".
    localparam logic [ADDR_W:0] C_FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    op_t                 r_last_op;
    logic [DATA_W-1:0]   r_wbuf;
    logic                r_wbuf_valid;
    logic [ADDR_W-1:0]   w_wr_ptr;
    logic [ADDR_W-1:0]   w_rd_ptr;
    logic                w_wr_elig;
    logic                w_rd_elig;
    logic                w_push_fire;
    logic                w_pop_fire;

    // ------------------------------------------------------------------
    // Pointers: each advances at the end of its own access cycle.
    // ------------------------------------------------------------------
    ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (r_state == ST_WRITE),
        .ptr   (w_wr_ptr)
    );

    ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (r_state == ST_READ),
        .ptr   (w_rd_ptr)
    );

    // ------------------------------------------------------------------
    // Handshakes and status
    // ------------------------------------------------------------------
    assign push_ready  = !r_wbuf_valid && (count != C_FULL_CNT);
    assign w_push_fire = push_valid && push_ready;
    assign w_pop_fire  = pop_valid && pop_ready;

    assign full  = (count == C_FULL_CNT);
    assign empty = (count == '0) && !r_wbuf_valid && !pop_valid;

    // A read is only useful when the output register can take the word.
    assign w_wr_elig = r_wbuf_valid;
    assign w_rd_elig = (count != '0) && !pop_valid;

    // The bus is driven only during the WRITE cycle; the reset of r_state
    // releases it asynchronously.
    assign ram_data = (r_state == ST_WRITE) ? r_wbuf : {DATA_W{1'bz}};

    // ------------------------------------------------------------------
    // Access sequencer with registered RAM strobes and address
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_last_op <= OP_READ;
            ram_we    <= 1'b0;
            ram_en    <= 1'b0;
            ram_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Contested grants go to the opposite of the last access.
                    if (w_wr_elig && (!w_rd_elig || (r_last_op == OP_READ))) begin
                        r_state  <= ST_WRITE;
                        ram_we   <= 1'b1;
                        ram_en   <= 1'b0;
                        ram_addr <= w_wr_ptr;
                    end else if (w_rd_elig) begin
                        r_state  <= ST_READ;
                        ram_we   <= 1'b0;
                        ram_en   <= 1'b1;
                        ram_addr <= w_rd_ptr;
                    end
                end
                ST_WRITE: begin
                    r_state   <= ST_IDLE;
                    r_last_op <= OP_WRITE;
                    ram_we    <= 1'b0;
                    ram_en    <= 1'b0;
                end
                ST_READ: begin
                    r_state   <= ST_IDLE;
                    r_last_op <= OP_READ;
                    ram_we    <= 1'b0;
                    ram_en    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    ram_we  <= 1'b0;
                    ram_en  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write buffer, occupancy count and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbuf       <= '0;
            r_wbuf_valid <= 1'b0;
            count        <= '0;
            pop_data     <= '0;
            pop_valid    <= 1'b0;
        end else begin
            // A push can never be accepted during WRITE (wbuf is still full),
            // so loading and clearing the buffer never collide.
            if (w_push_fire) begin
                r_wbuf       <= push_data;
                r_wbuf_valid <= 1'b1;
            end else if (r_state == ST_WRITE) begin
                r_wbuf_valid <= 1'b0;
            end

            if (r_state == ST_WRITE) begin
                count <= count + 1'b1;
            end else if (r_state == ST_READ) begin
                count <= count - 1'b1;
            end

            // READ is issued only while pop_valid is low, so a pop handshake
            // and a read commit are mutually exclusive.
            if (r_state == ST_READ) begin
                pop_data  <= ram_data;
                pop_valid <= 1'b1;
            end else if (w_pop_fire) begin
                pop_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_fifo_ctrl
//  Description : Scoreboard bench for ram_fifo_ctrl with a behavioural RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push_valid = 1'b0;
    logic       push_ready;
    logic [7:0] push_data = 8'h00;
    logic       pop_valid;
    logic       pop_ready = 1'b0;
    logic [7:0] pop_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       ram_we;
    logic       ram_en;
    logic [3:0] ram_addr;
    wire  [7:0] ram_data;

    ram_fifo_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ram_we     (ram_we),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data)
    );

    always #5 clk = ~clk;

    // Behavioural 16x8 single-port RAM: synchronous write, combinational read.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
    end
    assign ram_data = (ram_en && !ram_we) ? mem[ram_addr] : 8'hzz;

    // ------------------------------------------------------------------
    // Reference model: the FIFO as an ordered list of accepted words.
    // ------------------------------------------------------------------
    int         total = 0;
    int         bad   = 0;
    logic [7:0] acc_list [$];   // every accepted word since reset, in order
    logic [7:0] exp_q    [$];   // words accepted but not yet popped
    int         wr_cnt = 0;     // RAM writes seen
    int         rd_cnt = 0;     // RAM reads seen
    int         pop_cnt = 0;
    bit         mon_en = 1'b0;
    bit         arb_mode = 1'b0;
    bit         prev_acc = 1'b0;
    int         last_type = 0;  // 0 none, 1 write, 2 read
    bit         hold_valid = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit         acc_last = 1'b0;
    int         c_exp;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        acc_list.delete();
        wr_cnt     = 0;
        rd_cnt     = 0;
        pop_cnt    = 0;
        prev_acc   = 1'b0;
        last_type  = 0;
        hold_valid = 1'b0;
    endtask

    // One clock: sample the push handshake at the negedge, record it at the
    // accepting edge, then return just after that edge.
    task automatic step();
        bit acc;
        @(negedge clk);
        acc = push_valid && push_ready;
        @(posedge clk);
        if (acc) begin
            acc_list.push_back(push_data);
            exp_q.push_back(push_data);
        end
        acc_last = acc;
        #1;
    endtask

    task automatic do_reset();
        mon_en     = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        rst_n      = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_strobes", {ram_we, ram_en}, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                c_exp = wr_cnt - rd_cnt;
                chk("count", count, c_exp);
                chk("full", full, c_exp == 16);
                chk("empty", empty, exp_q.size() == 0);
                chk("push_ready", push_ready, (acc_list.size() == wr_cnt) && (c_exp < 16));
                chk("we_en_excl", ram_we & ram_en, 0);
                chk("turnaround", prev_acc & (ram_we | ram_en), 0);
                if (ram_we) begin
                    chk("wr_has_word", wr_cnt < acc_list.size(), 1);
                    chk("wr_addr", ram_addr, wr_cnt % 16);
                    if (wr_cnt < acc_list.size()) chk("wr_data", ram_data, acc_list[wr_cnt]);
                    if (arb_mode) chk("arb_w_after_w", last_type == 1, 0);
                    wr_cnt++;
                    last_type = 1;
                end
                if (ram_en) begin
                    chk("rd_has_word", rd_cnt < wr_cnt, 1);
                    chk("rd_addr", ram_addr, rd_cnt % 16);
                    if (rd_cnt < acc_list.size()) chk("rd_data", ram_data, acc_list[rd_cnt]);
                    if (arb_mode) chk("arb_r_after_w", last_type, 1);
                    rd_cnt++;
                    last_type = 2;
                end
                prev_acc = ram_we | ram_en;
                if (hold_valid) begin
                    chk("pop_hold_valid", pop_valid, 1);
                    chk("pop_hold_data", pop_data, hold_data);
                end
                hold_valid = pop_valid && !pop_ready;
                hold_data  = pop_data;
                if (pop_valid && pop_ready) begin
                    chk("pop_has_word", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("pop_data", pop_data, exp_q.pop_front());
                    pop_cnt++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int guard;
        int d;

        // Reset, then idle cycles with no strobe after release.
        do_reset();
        repeat (3) begin
            step();
            chk("post_rst_strobe", {ram_we, ram_en}, 0);
        end

        // Single word latency: accepted at edge E.
        push_valid = 1'b1;
        push_data  = 8'hA5;
        step();
        chk("single_accept", acc_last, 1);
        push_valid = 1'b0;
        step();                                     // E+1
        chk("single_we", ram_we, 1);
        chk("single_waddr", ram_addr, 0);
        chk("single_wdata", ram_data, 8'hA5);
        step();                                     // E+2
        chk("single_we_drop", ram_we, 0);
        chk("single_count1", count, 1);
        step();                                     // E+3
        chk("single_en", ram_en, 1);
        chk("single_raddr", ram_addr, 0);
        step();                                     // E+4
        chk("single_pop_valid", pop_valid, 1);
        chk("single_pop_data", pop_data, 8'hA5);
        chk("single_count0", count, 0);
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        step();

        // Fill: 17 words with no pops.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push_valid = 1'b1;
            push_data  = 8'(i);
            guard = 0;
            do begin
                step();
                guard++;
            end while (!acc_last && guard < 20);
            chk("fill_accept", acc_last, 1);
        end
        push_data = 8'h11;
        repeat (20) step();
        chk("fill_no_18th", acc_list.size(), 17);
        chk("fill_push_ready", push_ready, 0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_pop_data", pop_data, 8'h00);

        // Drain with wrap.
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        guard = 0;
        while (!empty && guard < 200) begin
            step();
            guard++;
        end
        chk("drain_empty", empty, 1);
        chk("drain_pops", pop_cnt, 17);
        pop_ready = 1'b0;

        // Arbitration under saturation.
        do_reset();
        arb_mode   = 1'b1;
        pop_ready  = 1'b1;
        push_valid = 1'b1;
        d = 1;
        repeat (80) begin
            push_data = 8'(d);
            step();
            if (acc_last) d++;
        end
        arb_mode   = 1'b0;
        push_valid = 1'b0;
        repeat (10) step();
        chk("arb_progress", wr_cnt >= 15, 1);
        chk("arb_drained", pop_cnt, acc_list.size());
        pop_ready = 1'b0;

        // Randomized traffic with fill-biased and drain-biased phases.
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            repeat (120) begin
                push_valid = ($urandom_range(0, 3) != 0);
                push_data  = 8'($urandom);
                pop_ready  = (ph % 2 == 0) ? ($urandom_range(0, 5) == 0)
                                           : ($urandom_range(0, 2) != 0);
                step();
            end
        end
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        guard = 0;
        while (!empty && guard < 300) begin
            step();
            guard++;
        end
        chk("rand_empty", empty, 1);
        chk("rand_all_popped", pop_cnt, acc_list.size());
        pop_ready = 1'b0;

        // Asynchronous reset in the middle of a WRITE.
        do_reset();
        push_valid = 1'b1;
        push_data  = 8'h77;
        step();
        push_valid = 1'b0;
        guard = 0;
        while (!ram_we && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("midw_saw_we", ram_we, 1);
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midw_we_drop", ram_we, 0);
        chk("midw_en_drop", ram_en, 0);
        chk("midw_count", count, 0);
        chk("midw_empty", empty, 1);
        chk("midw_push_ready", push_ready, 1);
        reset_model();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        push_valid = 1'b1;
        push_data  = 8'h3C;
        step();
        push_valid = 1'b0;
        guard = 0;
        while (!ram_we && guard < 10) begin
            step();
            guard++;
        end
        chk("midw_next_we", ram_we, 1);
        chk("midw_next_addr", ram_addr, 0);
        chk("midw_next_data", ram_data, 8'h3C);
        pop_ready = 1'b1;
        repeat (8) step();
        chk("midw_popped", pop_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
